cw_capture_buf: RTL and testbench

CW_CAPTURE_BUF -- requirements
Module: cw_capture_buf

---
 rtl/cw_pkg.sv | 15 +
 rtl/cw_sdp_ram.sv | 38 +++
 rtl/cw_capture_buf.sv | 205 ++++++++++++++++++++
 tb/tb_cw_capture_buf.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cw_pkg.sv
// Shared defaults and FSM state type for the capture buffer.
package cw_pkg;

  // 4 non-bus probe nodes plus a 42-bit bus.
  localparam int unsigned CwDataW = 46;
  localparam int unsigned CwAddrW = 10;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDrain,
    StDone
  } cw_state_e;

endpackage

// File: rtl/cw_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
module cw_sdp_ram
  import cw_pkg::*;
#(
  parameter int unsigned DATA_W = CwDataW,
  parameter int unsigned ADDR_W = CwAddrW
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [Depth];
  logic [DATA_W-1:0] r_rd_data;

  // Write port; contents are never reset so this maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cw_capture_buf.sv
// Capture buffer: stores watcher-core samples into a circular RAM while the
// capture window is open, then drains them oldest-first over valid/ready.
module cw_capture_buf
  import cw_pkg::*;
#(
  parameter int unsigned DATA_W = CwDataW,
  parameter int unsigned ADDR_W = CwAddrW
) (
  input  logic              trig_clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              wt_ce,
  input  logic              wt_en,
  input  logic [15:0]       wt_addr,
  input  logic [DATA_W-1:0] sample_din,
  input  logic              trig_hit,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_cnt,
  output logic [ADDR_W-1:0] trig_pos,
  output logic              trig_seen
);

  localparam int unsigned   Depth   = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   CntFull = (ADDR_W + 1)'(Depth);
  localparam logic [ADDR_W:0]   CntOne  = 1;
  localparam logic [ADDR_W-1:0] AddrOne = 1;

  cw_state_e         r_state;
  logic              r_wt_ce;
  logic              r_first_seen;
  logic [ADDR_W-1:0] r_first_addr;
  logic [ADDR_W-1:0] r_last_addr;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_trig_seen;
  logic [ADDR_W-1:0] r_trig_pos;
  logic [ADDR_W:0]   r_sample_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W:0]   r_issue_left;
  logic              r_inflight;
  logic              r_inflight_last;

  // Two-entry skid FIFO behind the RAM read port.
  logic [DATA_W-1:0] r_fifo_data [2];
  logic              r_fifo_last [2];
  logic [1:0]        r_fifo_cnt;
  logic              r_head;
  logic              r_tail;

  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_wr;
  logic              w_ce_fall;
  logic [ADDR_W-1:0] w_start;
  logic              w_pop;
  logic [1:0]        w_occ;
  logic              w_issue;
  logic [DATA_W-1:0] w_ram_q;
  logic              w_addr_unused;

  assign w_wr_addr     = wt_addr[ADDR_W-1:0];
  assign w_addr_unused = ^wt_addr[15:ADDR_W];

  assign w_wr      = (r_state == StCapture) && wt_ce && wt_en;
  // r_wt_ce is cleared on arm, so a high value proves one cycle of wt_ce high.
  assign w_ce_fall = (r_state == StCapture) && r_wt_ce && !wt_ce;

  // Once the buffer has wrapped, the oldest sample sits just past the newest.
  assign w_start = (r_sample_cnt == CntFull) ? (r_last_addr + AddrOne) : r_first_addr;

  assign w_pop = rd_valid && rd_ready;
  // FIFO occupancy after this cycle; also the next value of r_fifo_cnt.
  assign w_occ = r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
  // Issue a read only if its data is guaranteed a FIFO slot next cycle.
  assign w_issue = (r_state == StDrain) && (r_issue_left != '0) && (w_occ <= 2'd1);

  cw_sdp_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .i_clk    (trig_clk),
    .i_wr_en  (w_wr),
    .i_wr_addr(w_wr_addr),
    .i_wr_data(sample_din),
    .i_rd_en  (w_issue),
    .i_rd_addr(r_rd_addr),
    .o_rd_data(w_ram_q)
  );

  // Control FSM: capture bookkeeping, drain set-up and read issue.
  always_ff @(posedge trig_clk) begin
    if (rst) begin
      r_state         <= StIdle;
      r_wt_ce         <= 1'b0;
      r_first_seen    <= 1'b0;
      r_first_addr    <= '0;
      r_last_addr     <= '0;
      r_trig_addr     <= '0;
      r_trig_seen     <= 1'b0;
      r_trig_pos      <= '0;
      r_sample_cnt    <= '0;
      r_rd_addr       <= '0;
      r_issue_left    <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else if (arm) begin
      r_state         <= StCapture;
      r_wt_ce         <= 1'b0;
      r_first_seen    <= 1'b0;
      r_first_addr    <= '0;
      r_last_addr     <= '0;
      r_trig_addr     <= '0;
      r_trig_seen     <= 1'b0;
      r_trig_pos      <= '0;
      r_sample_cnt    <= '0;
      r_rd_addr       <= '0;
      r_issue_left    <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
        end
        StCapture: begin
          r_wt_ce <= wt_ce;
          if (w_wr) begin
            r_last_addr <= w_wr_addr;
            if (!r_first_seen) begin
              r_first_seen <= 1'b1;
              r_first_addr <= w_wr_addr;
            end
            if (r_sample_cnt != CntFull) begin
              r_sample_cnt <= r_sample_cnt + CntOne;
            end
            if (trig_hit && !r_trig_seen) begin
              r_trig_seen <= 1'b1;
              r_trig_addr <= w_wr_addr;
            end
          end
          if (w_ce_fall) begin
            if (r_sample_cnt != '0) begin
              r_state      <= StDrain;
              r_rd_addr    <= w_start;
              r_issue_left <= r_sample_cnt;
              r_trig_pos   <= r_trig_seen ? (r_trig_addr - w_start) : '0;
            end else begin
              r_state <= StDone;
            end
          end
        end
        StDrain: begin
          r_inflight      <= w_issue;
          r_inflight_last <= w_issue && (r_issue_left == CntOne);
          if (w_issue) begin
            r_rd_addr    <= r_rd_addr + AddrOne;
            r_issue_left <= r_issue_left - CntOne;
          end
          if (w_pop && rd_last) begin
            r_state <= StDone;
          end
        end
        StDone: begin
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Skid FIFO: RAM data pushes the cycle after issue, consumer pops on handshake.
  always_ff @(posedge trig_clk) begin
    if (rst || arm) begin
      r_fifo_cnt     <= 2'd0;
      r_head         <= 1'b0;
      r_tail         <= 1'b0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
    end else begin
      if (r_inflight) begin
        r_fifo_data[r_tail] <= w_ram_q;
        r_fifo_last[r_tail] <= r_inflight_last;
        r_tail              <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_fifo_cnt <= w_occ;
    end
  end

  // Outputs are zeroed when no beat is presented so reset leaves them all low.
  assign rd_valid   = (r_fifo_cnt != 2'd0);
  assign rd_data    = rd_valid ? r_fifo_data[r_head] : '0;
  assign rd_last    = rd_valid ? r_fifo_last[r_head] : 1'b0;
  assign busy       = (r_state == StCapture) || (r_state == StDrain);
  assign done       = (r_state == StDone);
  assign sample_cnt = r_sample_cnt;
  assign trig_pos   = r_trig_pos;
  assign trig_seen  = r_trig_seen;

endmodule

// File: tb/tb_cw_capture_buf.sv
// Directed bench for cw_capture_buf: capture, wrap, trigger, back-pressure,
// empty window and mid-readout reset.
module tb_cw_capture_buf;

  localparam int DW    = 46;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          trig_clk = 1'b0;
  logic          rst, arm, wt_ce, wt_en, trig_hit, rd_ready;
  logic [15:0]   wt_addr;
  logic [DW-1:0] sample_din;
  logic          rd_valid, rd_last, busy, done, trig_seen;
  logic [DW-1:0] rd_data;
  logic [AW:0]   sample_cnt;
  logic [AW-1:0] trig_pos;

  int errors;
  int checks;

  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  int            first_v, first_x, last_x;

  cw_capture_buf #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .trig_clk  (trig_clk),
    .rst       (rst),
    .arm       (arm),
    .wt_ce     (wt_ce),
    .wt_en     (wt_en),
    .wt_addr   (wt_addr),
    .sample_din(sample_din),
    .trig_hit  (trig_hit),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .done      (done),
    .sample_cnt(sample_cnt),
    .trig_pos  (trig_pos),
    .trig_seen (trig_seen)
  );

  always #5 trig_clk = ~trig_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge trig_clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wr(input logic ce, input logic [15:0] a, input logic [DW-1:0] d,
                    input logic th);
    wt_ce      = ce;
    wt_en      = 1'b1;
    wt_addr    = a;
    sample_din = d;
    trig_hit   = th;
    tick();
    wt_en    = 1'b0;
    trig_hit = 1'b0;
  endtask

  task automatic end_cap();
    wt_ce = 1'b0;
    tick();
  endtask

  // Collect n beats; checks hold-while-stalled on every stalled cycle.
  task automatic collect(input string tag, input int n, input bit rand_rdy, input int budget);
    logic          held_v;
    logic [DW-1:0] held_d;
    logic          held_l;
    int            k;
    got_d.delete();
    got_l.delete();
    first_v = -1;
    first_x = -1;
    last_x  = -1;
    held_v  = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    k       = 0;
    while (got_d.size() < n && k < budget) begin
      rd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held_v) begin
        chk({tag, "_stall_valid"}, 64'(rd_valid), 64'(1));
        chk({tag, "_stall_data"}, 64'(rd_data), 64'(held_d));
        chk({tag, "_stall_last"}, 64'(rd_last), 64'(held_l));
      end
      if (rd_valid && first_v < 0) first_v = k;
      if (rd_valid && rd_ready) begin
        got_d.push_back(rd_data);
        got_l.push_back(rd_last);
        if (first_x < 0) first_x = k;
        last_x = k;
      end
      held_v = rd_valid && !rd_ready;
      held_d = rd_data;
      held_l = rd_last;
      tick();
      k++;
    end
    rd_ready = 1'b0;
    chk({tag, "_beat_count"}, 64'(got_d.size()), 64'(n));
  endtask

  // Beat i must carry base+i, with rd_last only on beat n-1.
  task automatic check_beats(input string tag, input logic [DW-1:0] base, input int n);
    int bad_d;
    int bad_l;
    bad_d = 0;
    bad_l = 0;
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_d[i] !== base + DW'(i)) bad_d++;
      if (got_l[i] !== (i == n - 1)) bad_l++;
    end
    chk({tag, "_data_errs"}, 64'(bad_d), 64'(0));
    chk({tag, "_last_errs"}, 64'(bad_l), 64'(0));
  endtask

  initial begin
    int  n_xfer;
    bit  hit;
    bit  seen;
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    arm        = 1'b0;
    wt_ce      = 1'b0;
    wt_en      = 1'b0;
    wt_addr    = '0;
    sample_din = '0;
    trig_hit   = 1'b0;
    rd_ready   = 1'b0;
    tick();
    tick();

    // Reset state.
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_rd_last", 64'(rd_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_trig_seen", 64'(trig_seen), 64'(0));
    chk("rst_sample_cnt", 64'(sample_cnt), 64'(0));
    chk("rst_trig_pos", 64'(trig_pos), 64'(0));
    rst = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'(0));

    // Eight samples at 0..7, drained in order at full rate.
    do_arm();
    chk("t1_busy_capture", 64'(busy), 64'(1));
    for (int i = 0; i < 8; i++) wr(1'b1, 16'(i), DW'(32'h10 + i), 1'b0);
    chk("t1_sample_cnt", 64'(sample_cnt), 64'(8));
    end_cap();
    chk("t1_busy_drain", 64'(busy), 64'(1));
    chk("t1_done_drain", 64'(done), 64'(0));
    collect("t1", 8, 1'b0, 40);
    chk("t1_first_valid_latency", 64'(first_v >= 0 && first_v <= 2), 64'(1));
    chk("t1_throughput", 64'(last_x - first_x), 64'(7));
    check_beats("t1", DW'(32'h10), 8);
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_busy_end", 64'(busy), 64'(0));
    chk("t1_rd_valid_end", 64'(rd_valid), 64'(0));
    tick();
    tick();
    chk("t1_done_hold", 64'(done), 64'(1));

    // DEPTH+5 writes wrap; oldest surviving sample is the one at addr 5.
    do_arm();
    for (int i = 0; i < DEPTH + 5; i++) wr(1'b1, 16'(i % DEPTH), DW'(i), 1'b0);
    chk("t2_sample_cnt", 64'(sample_cnt), 64'(DEPTH));
    end_cap();
    chk("t2_trig_seen", 64'(trig_seen), 64'(0));
    collect("t2", DEPTH, 1'b0, DEPTH + 20);
    check_beats("t2", DW'(5), DEPTH);
    chk("t2_done", 64'(done), 64'(1));

    // Trigger on the 4th of 8 writes from addr 100; stray triggers ignored.
    do_arm();
    wt_ce    = 1'b1;
    trig_hit = 1'b1;
    tick();
    trig_hit = 1'b0;
    chk("t3_trig_without_write", 64'(trig_seen), 64'(0));
    for (int i = 0; i < 8; i++) wr(1'b1, 16'(100 + i), DW'(32'h100 + i), (i == 3 || i == 5));
    end_cap();
    chk("t3_trig_seen", 64'(trig_seen), 64'(1));
    chk("t3_trig_pos", 64'(trig_pos), 64'(3));
    collect("t3", 8, 1'b0, 40);
    check_beats("t3", DW'(32'h100), 8);
    chk("t3_trig_pos_done", 64'(trig_pos), 64'(3));

    // 16 beats under random back-pressure; wt_en without wt_ce ignored.
    do_arm();
    wr(1'b0, 16'd199, DW'(32'hBAD), 1'b0);
    for (int i = 0; i < 16; i++) wr(1'b1, 16'h1000 | 16'(200 + i), DW'(32'hA000 + i), 1'b0);
    chk("t4_sample_cnt", 64'(sample_cnt), 64'(16));
    end_cap();
    collect("t4", 16, 1'b1, 400);
    check_beats("t4", DW'(32'hA000), 16);
    chk("t4_done", 64'(done), 64'(1));

    // Window opens and closes with no writes: straight to DONE.
    do_arm();
    wt_ce = 1'b1;
    tick();
    tick();
    tick();
    wt_ce = 1'b0;
    tick();
    chk("t5_done", 64'(done), 64'(1));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_sample_cnt", 64'(sample_cnt), 64'(0));
    rd_ready = 1'b1;
    seen     = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (rd_valid) seen = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    chk("t5_no_rd_valid", 64'(seen), 64'(0));

    // Reset while the 3rd readout beat is presented.
    do_arm();
    for (int i = 0; i < 8; i++) wr(1'b1, 16'(i), DW'(32'h30 + i), (i == 1));
    end_cap();
    rd_ready = 1'b1;
    n_xfer   = 0;
    hit      = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (rd_valid && n_xfer == 2) begin
        rst = 1'b1;
        hit = 1'b1;
      end else if (rd_valid) begin
        n_xfer++;
      end
      tick();
    end
    rst = 1'b0;
    chk("t6_reached_beat3", 64'(hit), 64'(1));
    chk("t6_rd_valid", 64'(rd_valid), 64'(0));
    chk("t6_rd_data", 64'(rd_data), 64'(0));
    chk("t6_rd_last", 64'(rd_last), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_done", 64'(done), 64'(0));
    chk("t6_sample_cnt", 64'(sample_cnt), 64'(0));
    chk("t6_trig_pos", 64'(trig_pos), 64'(0));
    chk("t6_trig_seen", 64'(trig_seen), 64'(0));
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (rd_valid) seen = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    chk("t6_no_rd_valid_after_rst", 64'(seen), 64'(0));

    // Reset wins over a simultaneous arm.
    rst = 1'b1;
    arm = 1'b1;
    tick();
    rst = 1'b0;
    arm = 1'b0;
    chk("t6_rst_over_arm_busy", 64'(busy), 64'(0));

    // Normal capture after the abandoned one.
    do_arm();
    for (int i = 0; i < 4; i++) wr(1'b1, 16'(50 + i), DW'(32'h40 + i), 1'b0);
    end_cap();
    chk("t6b_sample_cnt", 64'(sample_cnt), 64'(4));
    collect("t6b", 4, 1'b0, 20);
    check_beats("t6b", DW'(32'h40), 4);
    chk("t6b_done", 64'(done), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
